// File: rtl/count_seq_ctrl.sv
// Sequencer that steps an external up/down counter from its current value to a target.
// Define COUNT_SEQ_PRESCALE_EN to add a PW-bit prescaler that spaces steps presc+1 cycles apart.
module count_seq_ctrl #(
    parameter int N  = 20,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [N-1:0]  target,
    input  logic          pause,
    input  logic          abort,
    input  logic [PW-1:0] presc,
    input  logic [N-1:0]  count,
    output logic          cnt_en,
    output logic          cnt_cw,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  steps
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   target_q, target_d;
    logic           cw_q, cw_d;
    logic [N-1:0]   steps_q, steps_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           accept;
    logic           at_target;
    logic           tick;

    assign accept    = ((state_q == IDLE) || (state_q == DONE)) && start && !abort;
    assign at_target = (count == target_q);

`ifdef COUNT_SEQ_PRESCALE_EN
    logic [PW-1:0]  pcnt_q, pcnt_d;

    assign tick = (pcnt_q == '0);

    // The down-counter only moves while RUN is actually stepping, so it freezes in PAUSE.
    always_comb begin
        pcnt_d = pcnt_q;
        if (accept) begin
            pcnt_d = presc;
        end else if ((state_q == RUN) && !pause && !abort) begin
            pcnt_d = tick ? presc : pcnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end
`else
    logic presc_unused;

    assign tick         = 1'b1;
    assign presc_unused = ^presc;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cw_d     = cw_q;
        steps_d  = steps_q;
        cnt_en   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    target_d = target;
                    cw_d     = (target > count);
                    steps_d  = '0;
                    state_d  = RUN;
                end else if (abort) begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                // Priority: abort, then pause, then arrival, then stepping.
                if (abort) begin
                    state_d = IDLE;
                end else if (pause) begin
                    state_d = PAUSE;
                end else if (at_target) begin
                    state_d = DONE;
                end else if (tick) begin
                    cnt_en  = 1'b1;
                    steps_d = steps_q + 1'b1;
                end
            end
            PAUSE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN) || (state_d == PAUSE);
        done_d = (state_d == DONE);
    end

    // NOTE: non-blocking updates so every flop samples the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= '0;
            cw_q     <= 1'b0;
            steps_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cw_q     <= cw_d;
            steps_q  <= steps_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign cnt_cw = cw_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign steps  = steps_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: models the external up/down counter and scores each move on done.
`timescale 1ns/1ps
module tb_count_seq_ctrl;

    localparam int N  = 20;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  target;
    logic          pause;
    logic          abort;
    logic [PW-1:0] presc;
    logic [N-1:0]  count = '0;
    logic          cnt_en;
    logic          cnt_cw;
    logic          busy;
    logic          done;
    logic [N-1:0]  steps;

    logic          load_req = 1'b0;
    logic [N-1:0]  load_val = '0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0] steps;
        logic [N-1:0] final_cnt;
        logic         cw;
    } exp_t;

    exp_t sb_q[$];

    count_seq_ctrl #(.N(N), .PW(PW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .target (target),
        .pause  (pause),
        .abort  (abort),
        .presc  (presc),
        .count  (count),
        .cnt_en (cnt_en),
        .cnt_cw (cnt_cw),
        .busy   (busy),
        .done   (done),
        .steps  (steps)
    );

    always #5 clk = ~clk;

    // External up/down counter driven by cnt_en / cnt_cw; the bench can preload it.
    always @(posedge clk) begin
        if (load_req) begin
            count <= load_val;
        end else if (cnt_en === 1'b1) begin
            count <= (cnt_cw === 1'b1) ? count + 1'b1 : count - 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic nclk();
        @(negedge clk);
        #1;
    endtask

    task automatic set_count(input logic [N-1:0] v);
        load_req = 1'b1;
        load_val = v;
        nclk();
        load_req = 1'b0;
    endtask

    // Drive a one-cycle start and push the expected outcome of the move.
    task automatic issue_start(input logic [N-1:0] tgt);
        exp_t e;
        e.cw        = (tgt > count);
        e.steps     = e.cw ? tgt - count : count - tgt;
        e.final_cnt = tgt;
        sb_q.push_back(e);
        start  = 1'b1;
        target = tgt;
        nclk();
        start  = 1'b0;
        target = ~tgt;
    endtask

    task automatic wait_done(input int budget, input logic exp_cw,
                             output int cyc, output int ens, output int first_en,
                             output int last_en, output int cw_bad, output bit timed_out);
        cyc = 1; ens = 0; first_en = -1; last_en = -1; cw_bad = 0; timed_out = 1'b0;
        while (done !== 1'b1 && !timed_out) begin
            if (cnt_en === 1'b1) begin
                ens++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
            end
            if (cnt_cw !== exp_cw) cw_bad++;
            if (cyc >= budget) begin
                timed_out = 1'b1;
            end else begin
                nclk();
                cyc++;
            end
        end
    endtask

    task automatic wait_steps(input logic [N-1:0] want, input int budget, input string name);
        int i = 0;
        while (steps !== want && i < budget) begin
            nclk();
            i++;
        end
        total++;
        if (steps !== want) begin
            bad++;
            $display("FAIL %s_reach_steps: got %0d required %0d", name, steps, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; target = '0; pause = 1'b0; abort = 1'b0; presc = '0;
        repeat (3) nclk();
        total++; if (cnt_en !== 1'b0) begin bad++; $display("FAIL rst_cnt_en: got %b required 0", cnt_en); end
        total++; if (cnt_cw !== 1'b0) begin bad++; $display("FAIL rst_cnt_cw: got %b required 0", cnt_cw); end
        total++; if (busy   !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
        total++; if (done   !== 1'b0) begin bad++; $display("FAIL rst_done: got %b required 0", done); end
        total++; if (steps  !== '0)   begin bad++; $display("FAIL rst_steps: got %0d required 0", steps); end
        rst_n = 1'b1;
        repeat (2) nclk();
        total++; if (busy !== 1'b0 || cnt_en !== 1'b0) begin
            bad++; $display("FAIL rst_idle_after_release: busy=%b cnt_en=%b required 0/0", busy, cnt_en);
        end
    endtask

    task automatic test_up();
        int cyc, ens, f, l, cwb; bit to; exp_t e;
        set_count(20'd5);
        issue_start(20'd9);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL up_busy: got %b required 1", busy); end
        wait_done(40, 1'b1, cyc, ens, f, l, cwb, to);
        e = sb_q.pop_front();
        total++; if (to) begin bad++; $display("FAIL up_timeout: done never rose"); end
        total++; if (cwb != 0 || cnt_cw !== e.cw) begin bad++; $display("FAIL up_cw: got %b required %b", cnt_cw, e.cw); end
        total++; if (ens != 4 || (l - f + 1) != 4) begin bad++; $display("FAIL up_enables: got %0d span %0d required 4 consecutive", ens, l - f + 1); end
        total++; if (cyc != 6) begin bad++; $display("FAIL up_done_latency: got %0d required 6", cyc); end
        total++; if (steps !== e.steps) begin bad++; $display("FAIL up_steps: got %0d required %0d", steps, e.steps); end
        total++; if (count !== e.final_cnt) begin bad++; $display("FAIL up_count: got %0d required %0d", count, e.final_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL up_busy_done: got %b required 0", busy); end
    endtask

    task automatic test_down();
        int cyc, ens, f, l, cwb; bit to; exp_t e;
        set_count(20'd9);
        issue_start(20'd2);
        wait_done(40, 1'b0, cyc, ens, f, l, cwb, to);
        e = sb_q.pop_front();
        total++; if (to) begin bad++; $display("FAIL down_timeout: done never rose"); end
        total++; if (cwb != 0 || cnt_cw !== 1'b0) begin bad++; $display("FAIL down_cw: got %b required 0", cnt_cw); end
        total++; if (ens != 7 || (l - f + 1) != 7) begin bad++; $display("FAIL down_enables: got %0d required 7", ens); end
        total++; if (count !== e.final_cnt) begin bad++; $display("FAIL down_count: got %0d required %0d", count, e.final_cnt); end
        total++; if (steps !== e.steps || done !== 1'b1) begin bad++; $display("FAIL down_steps: got %0d/%b required %0d/1", steps, done, e.steps); end
    endtask

    task automatic test_equal();
        int cyc, ens, f, l, cwb; bit to; exp_t e;
        set_count(20'd3);
        issue_start(20'd3);
        wait_done(20, 1'b0, cyc, ens, f, l, cwb, to);
        e = sb_q.pop_front();
        total++; if (to || cyc != 2) begin bad++; $display("FAIL equal_done_latency: got %0d required 2", cyc); end
        total++; if (ens != 0) begin bad++; $display("FAIL equal_enables: got %0d required 0", ens); end
        total++; if (steps !== e.steps || count !== 20'd3) begin bad++; $display("FAIL equal_steps: got %0d count %0d required 0 count 3", steps, count); end
    endtask

    task automatic test_pause();
        int cyc, ens, f, l, cwb; bit to; exp_t e; int leak = 0;
        set_count(20'd0);
        issue_start(20'd100);
        wait_steps(20'd20, 100, "pause");
        pause = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (cnt_en !== 1'b0 || busy !== 1'b1) leak++;
            nclk();
        end
        total++; if (leak != 0) begin bad++; $display("FAIL pause_hold: got %0d bad cycles required 0", leak); end
        total++; if (steps !== 20'd20 || count !== 20'd20) begin bad++; $display("FAIL pause_frozen: got steps %0d count %0d required 20/20", steps, count); end
        pause = 1'b0;
        wait_done(200, 1'b1, cyc, ens, f, l, cwb, to);
        e = sb_q.pop_front();
        total++; if (to || ens != 80) begin bad++; $display("FAIL pause_resume_enables: got %0d required 80", ens); end
        total++; if (steps !== e.steps || count !== e.final_cnt || done !== 1'b1) begin
            bad++; $display("FAIL pause_result: got steps %0d count %0d done %b required %0d/%0d/1", steps, count, done, e.steps, e.final_cnt);
        end
    endtask

    task automatic test_abort();
        set_count(20'd0);
        start = 1'b1; target = 20'd50;
        nclk();
        start = 1'b0;
        wait_steps(20'd3, 20, "abort");
        start = 1'b1; target = 20'd0;
        nclk();
        start = 1'b0;
        total++; if (steps !== 20'd4 || cnt_cw !== 1'b1) begin bad++; $display("FAIL abort_start_ignored: got steps %0d cw %b required 4/1", steps, cnt_cw); end
        wait_steps(20'd6, 20, "abort");
        abort = 1'b1;
        #1;
        total++; if (cnt_en !== 1'b0) begin bad++; $display("FAIL abort_same_cycle: got cnt_en %b required 0", cnt_en); end
        nclk();
        abort = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_idle: got busy %b done %b required 0/0", busy, done); end
        nclk();
        total++; if (steps !== 20'd6 || count !== 20'd6 || cnt_en !== 1'b0) begin
            bad++; $display("FAIL abort_hold: got steps %0d count %0d en %b required 6/6/0", steps, count, cnt_en);
        end
        start = 1'b1; abort = 1'b1; target = 20'd40;
        nclk();
        start = 1'b0; abort = 1'b0;
        nclk();
        total++; if (busy !== 1'b0 || steps !== 20'd6) begin bad++; $display("FAIL abort_start_idle: got busy %b steps %0d required 0/6", busy, steps); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] tgts [4];
        int cyc, ens, f, l, cwb; bit to; exp_t e;
        tgts[0] = 20'd20; tgts[1] = 20'd15; tgts[2] = 20'd15; tgts[3] = 20'd30;
        for (int k = 0; k < 4; k++) begin
            issue_start(tgts[k]);
            wait_done(100, sb_q[$].cw, cyc, ens, f, l, cwb, to);
            e = sb_q.pop_front();
            total++;
            if (to || cwb != 0 || ens != int'(e.steps) || steps !== e.steps || count !== e.final_cnt) begin
                bad++;
                $display("FAIL b2b_move%0d: got steps %0d en %0d count %0d required %0d/%0d", k, steps, ens, count, e.steps, e.final_cnt);
            end
        end
        start = 1'b1; abort = 1'b1; target = 20'd0;
        nclk();
        start = 1'b0; abort = 1'b0;
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL b2b_abort_done: got done %b busy %b required 0/0", done, busy); end
    endtask

    task automatic test_reset_midrun();
        logic [N-1:0] c_at_rst;
        set_count(20'd0);
        start = 1'b1; target = 20'd500;
        nclk();
        start = 1'b0;
        wait_steps(20'd5, 20, "rstrun");
        rst_n = 1'b0;
        c_at_rst = count;
        #1;
        total++; if ({cnt_en, cnt_cw, busy, done} !== 4'b0000 || steps !== '0) begin
            bad++; $display("FAIL rstrun_async: got en %b cw %b busy %b done %b steps %0d required all 0", cnt_en, cnt_cw, busy, done, steps);
        end
        nclk();
        rst_n = 1'b1;
        repeat (2) nclk();
        total++; if (cnt_en !== 1'b0 || busy !== 1'b0 || count !== c_at_rst) begin
            bad++; $display("FAIL rstrun_release: got en %b busy %b count %0d required 0/0/%0d", cnt_en, busy, count, c_at_rst);
        end
    endtask

    task automatic test_prescale();
        int cyc, ens, f, l, cwb; bit to; exp_t e;
        presc = 8'd3;
        set_count(20'd10);
        issue_start(20'd12);
        wait_done(60, 1'b1, cyc, ens, f, l, cwb, to);
        e = sb_q.pop_front();
`ifdef COUNT_SEQ_PRESCALE_EN
        total++; if (to || ens != 2 || f != 4 || (l - f) != 4) begin
            bad++; $display("FAIL presc_spacing: got %0d pulses first %0d gap %0d required 2/4/4", ens, f, l - f);
        end
`else
        total++; if (to || ens != 2 || f != 1 || (l - f) != 1) begin
            bad++; $display("FAIL presc_ignored: got %0d pulses first %0d gap %0d required 2/1/1", ens, f, l - f);
        end
`endif
        total++; if (steps !== e.steps || count !== e.final_cnt) begin bad++; $display("FAIL presc_result: got %0d/%0d required %0d/%0d", steps, count, e.steps, e.final_cnt); end
        start = 1'b1; target = 20'd50;
        nclk();
        start = 1'b0;
        wait_steps(20'd1, 20, "presc_rst");
        rst_n = 1'b0;
        #1;
        total++; if ({cnt_en, cnt_cw, busy, done} !== 4'b0000 || steps !== '0) begin
            bad++; $display("FAIL presc_rst_outputs: got en %b cw %b busy %b done %b steps %0d required all 0", cnt_en, cnt_cw, busy, done, steps);
        end
        nclk();
        rst_n = 1'b1;
        presc = '0;
        nclk();
    endtask

    initial begin
        test_reset();
        test_up();
        test_down();
        test_equal();
        test_pause();
        test_abort();
        test_back_to_back();
        test_reset_midrun();
        test_prescale();
        total++; if (sb_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d left required 0", sb_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_seq_ctrl.md
COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 20, giving the width of the sequenced counter value.
REQ-002 The block SHALL have parameter PW, default 8, giving the width of the step prescaler value.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a request to move the counter to target.
REQ-006 The block SHALL have port target, input, N bits: the destination value, sampled only when start is accepted.
REQ-007 The block SHALL have port pause, input, 1 bit: while high, stepping is suspended.
REQ-008 The block SHALL have port abort, input, 1 bit: cancels the current operation.
REQ-009 The block SHALL have port presc, input, PW bits: the step interval minus 1 (used only when the macro of REQ-029 is defined).
REQ-010 The block SHALL have port count, input, N bits: the current value fed back from the sequenced up/down counter.
REQ-011 The block SHALL have port cnt_en, output, 1 bit: the step enable driven to the counter's en input.
REQ-012 The block SHALL have port cnt_cw, output, 1 bit: the direction to the counter (1 = increment, 0 = decrement).
REQ-013 The block SHALL have port busy, output, 1 bit: high in states RUN and PAUSE.
REQ-014 The block SHALL have port done, output, 1 bit: high in state DONE.
REQ-015 The block SHALL have port steps, output, N bits: the number of cnt_en pulses issued since the last accepted start.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, PAUSE and DONE.
REQ-017 start SHALL be accepted in IDLE or DONE only and ignored otherwise; on acceptance the block SHALL latch target into target_q, latch cnt_cw = (target > count), clear steps, and enter RUN on the next edge.
REQ-018 In RUN, cnt_en SHALL be combinational: cnt_en = tick && !pause && !abort && (count != target_q), where tick is constant 1 without the prescaler.
REQ-019 In RUN, count == target_q SHALL cause a transition to DONE on the next edge with no step issued, so the counter never overshoots.
REQ-020 A start with target equal to count SHALL pass through RUN for one cycle and reach DONE with steps = 0.
REQ-021 RUN with pause high SHALL go to PAUSE; PAUSE with pause low SHALL return to RUN; cnt_en SHALL be 0 in PAUSE.
REQ-022 abort in RUN or PAUSE SHALL force cnt_en low in the same cycle and enter IDLE on the next edge, with steps holding its value.
REQ-023 abort SHALL take priority over pause, and pause SHALL take priority over stepping; abort and start asserted together in IDLE/DONE SHALL result in IDLE with start ignored.
REQ-024 cnt_cw SHALL hold its latched value until the next accepted start, and SHALL never change during RUN or PAUSE.
REQ-025 steps SHALL increment by 1 on each edge where cnt_en = 1, wrapping modulo 2^N.
REQ-026 The block SHALL NOT wrap count: the direction is chosen by magnitude comparison, so the path never crosses 0 or 2^N-1.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, cnt_en=0, cnt_cw=0, busy=0, done=0, steps=0, target_q=0, and prescaler count=0, independent of clk.
REQ-028 Reset asserted mid-RUN SHALL drop cnt_en asynchronously and SHALL NOT issue a step on release; the block SHALL then wait for a new start.

Configuration
REQ-029 When COUNT_SEQ_PRESCALE_EN is defined, the block SHALL contain a PW-bit down-counter, reloaded with presc on start acceptance and on each tick; tick = (down-counter == 0) in RUN, giving one step every presc+1 cycles; the down-counter SHALL freeze in PAUSE.
REQ-030 When COUNT_SEQ_PRESCALE_EN is undefined, tick SHALL be 1, presc SHALL be ignored, and no prescaler logic SHALL be present.

Verification
REQ-031 The bench SHALL cover: count=5, start with target=9 -> cnt_cw=1, exactly 4 consecutive cnt_en cycles, done=1, steps=4.
REQ-032 The bench SHALL cover: count=9, start with target=2 -> cnt_cw=0, 7 cnt_en cycles, final count=2, done=1, steps=7.
REQ-033 The bench SHALL cover: count=3, start with target=3 -> no cnt_en, DONE two cycles after start, steps=0.
REQ-034 The bench SHALL cover: target=100 from count 0, pause held high for 10 cycles after 20 steps -> cnt_en=0 during the pause, completion with steps=100, done=1.
REQ-035 The bench SHALL cover: abort after 6 steps -> cnt_en=0 in the same cycle, IDLE, steps=6; a start during RUN is ignored.
REQ-036 The bench SHALL cover, with COUNT_SEQ_PRESCALE_EN defined: presc=3, target=count+2 -> cnt_en pulses spaced 4 cycles apart; rst_n low mid-run -> all outputs 0 immediately.
